// File: rtl/aram_arbiter_ram.sv
`default_nettype none
// ============================================================================
// Module      : aram_arbiter_ram
// Description : Single-ported audio RAM shared by CPU (A) and DSP (B) through
//               a round-robin req/ack arbiter, with a post-reset clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module aram_arbiter_ram #(
  parameter int unsigned            ADDR_WIDTH     = 16,
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]  FILL_VALUE     = '0,
  parameter bit                     CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  localparam int unsigned c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam state_t c_RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_last_grant_b;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;

  // Power-up content matches the clear value so CLEAR_ON_RESET=0 still reads FILL_VALUE.
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH] = '{default: FILL_VALUE};

  logic                  w_elig_a;
  logic                  w_elig_b;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // A port whose ack is high this cycle sits out, so dropping req after ack is safe.
  assign w_elig_a = a_req & ~r_a_ack;
  assign w_elig_b = b_req & ~r_b_ack;

  always_comb begin
    w_state_next = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_clr_cnt;
    w_mem_wdata  = FILL_VALUE;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we = 1'b1;
        if (r_clr_cnt == c_LAST_ADDR) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_grant_a = w_elig_a & (~w_elig_b | r_last_grant_b);
        w_grant_b = w_elig_b & (~w_elig_a | ~r_last_grant_b);
        if (w_grant_a) begin
          w_mem_we    = a_we;
          w_mem_addr  = a_addr;
          w_mem_wdata = a_wdata;
        end else if (w_grant_b) begin
          w_mem_we    = b_we;
          w_mem_addr  = b_addr;
          w_mem_wdata = b_wdata;
        end
      end
      default: w_state_next = c_RESET_STATE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= c_RESET_STATE;
      r_clr_cnt      <= '0;
      r_last_grant_b <= 1'b1;
      r_a_ack        <= 1'b0;
      r_b_ack        <= 1'b0;
      r_a_rdata      <= '0;
      r_b_rdata      <= '0;
    end else begin
      r_state <= w_state_next;
      r_a_ack <= w_grant_a;
      r_b_ack <= w_grant_b;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
      if (w_grant_a | w_grant_b) begin
        r_last_grant_b <= w_grant_b;
      end
      if (w_grant_a & ~a_we) begin
        r_a_rdata <= r_mem[w_mem_addr];
      end
      if (w_grant_b & ~b_we) begin
        r_b_rdata <= r_mem[w_mem_addr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign busy    = (r_state == ST_CLEAR);
  assign a_ack   = r_a_ack;
  assign b_ack   = r_b_ack;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule
`default_nettype wire
